// File: rtl/vid_timing_gen.sv
// Raster timing generator: shadowed configuration, sync/blank decode, pixel
// position and one-clock line fetch requests for the bus-master stage.
module vid_timing_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [5:0]  pcnt,
   input  logic [12:0] hsize,
   input  logic [12:0] hend,
   input  logic [12:0] hss,
   input  logic [12:0] hse,
   input  logic [12:0] vsize,
   input  logic [12:0] vend,
   input  logic [12:0] vss,
   input  logic [12:0] vse,
   input  logic [31:0] base_address,
   input  logic [31:0] lineinc,
   output logic        hsync,
   output logic        hblank,
   output logic        vsync,
   output logic        vblank,
   output logic        pix_valid,
   output logic [12:0] hcount,
   output logic [12:0] vcount,
   output logic        line_req,
   output logic [31:0] line_addr,
   output logic        cfg_err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

   typedef struct packed {
      logic [5:0]  pcnt;
      logic [12:0] hsize;
      logic [12:0] hend;
      logic [12:0] hss;
      logic [12:0] hse;
      logic [12:0] vsize;
      logic [12:0] vend;
      logic [12:0] vss;
      logic [12:0] vse;
      logic [31:0] base;
      logic [31:0] inc;
   } cfg_t;

   state_t      state;
   cfg_t        shd, cfg_in, cfg;
   logic [5:0]  dcnt, dcnt_nx;
   logic [12:0] h_nx, v_nx, nl;
   logic        first, tick, h_wrap, f_wrap, adv;
   logic        lreq_nx, pv_nx, hb_nx, vb_nx, hs_nx, vs_nx;
   logic [31:0] addr_nx;

   function automatic logic illegal(input cfg_t c);
      return ({1'b0, c.hsize} > {1'b0, c.hend} + 14'd1) ||
             ({1'b0, c.vsize} > {1'b0, c.vend} + 14'd1) ||
             (c.hend == 13'd0) || (c.vend == 13'd0);
   endfunction

   assign cfg_in = {pcnt, hsize, hend, hss, hse, vsize, vend, vss, vse,
                    base_address, lineinc};

   // Everything below is the value of the next raster position; the decodes
   // see the freshly loaded inputs on the first RUN clock and at a frame wrap.
   always_comb begin
      first   = (state == LOAD);
      tick    = !first && (dcnt == shd.pcnt);
      h_wrap  = tick && (hcount == shd.hend);
      f_wrap  = h_wrap && (vcount == shd.vend);
      cfg     = (first || f_wrap) ? cfg_in : shd;
      dcnt_nx = tick ? 6'd0 : dcnt + 6'd1;
      h_nx    = hcount;
      v_nx    = vcount;
      if (first) begin
         dcnt_nx = 6'd0;
         h_nx    = 13'd0;
         v_nx    = 13'd0;
      end else begin
         if (tick)   h_nx = h_wrap ? 13'd0 : hcount + 13'd1;
         if (h_wrap) v_nx = (vcount == shd.vend) ? 13'd0 : vcount + 13'd1;
      end
      nl      = (first || v_nx == cfg.vend) ? 13'd0 : v_nx + 13'd1;
      lreq_nx = (first || (tick && h_nx == cfg.hsize)) && (nl < cfg.vsize);
      addr_nx = cfg.base + 32'(nl) * cfg.inc;
      hb_nx   = h_nx >= cfg.hsize;
      vb_nx   = v_nx >= cfg.vsize;
      hs_nx   = (h_nx >= cfg.hss) && (h_nx < cfg.hse);
      vs_nx   = (v_nx >= cfg.vss) && (v_nx < cfg.vse);
      pv_nx   = (dcnt_nx == cfg.pcnt) && !hb_nx && !vb_nx;
      adv     = (first && !illegal(cfg_in)) ||
                (state == RUN && en && !illegal(shd));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shd       <= '0;
         dcnt      <= '0;
         hcount    <= '0;
         vcount    <= '0;
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         hblank    <= 1'b1;
         vblank    <= 1'b1;
         pix_valid <= 1'b0;
         line_req  <= 1'b0;
         line_addr <= '0;
         cfg_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cfg_err <= 1'b0;
               if (en) state <= LOAD;
            end
            LOAD: begin
               shd     <= cfg_in;
               cfg_err <= illegal(cfg_in);
               state   <= illegal(cfg_in) ? ERR : RUN;
            end
            RUN: begin
               cfg_err <= en && illegal(shd);
               if (!en)                state <= IDLE;
               else if (illegal(shd))  state <= ERR;
               else if (f_wrap)        shd   <= cfg_in;
            end
            default: begin
               cfg_err <= en;
               if (!en) state <= IDLE;
            end
         endcase

         if (adv) begin
            dcnt      <= dcnt_nx;
            hcount    <= h_nx;
            vcount    <= v_nx;
            hsync     <= hs_nx;
            vsync     <= vs_nx;
            hblank    <= hb_nx;
            vblank    <= vb_nx;
            pix_valid <= pv_nx;
            line_req  <= lreq_nx;
            if (lreq_nx) line_addr <= addr_nx;
         end else begin
            dcnt      <= '0;
            hcount    <= '0;
            vcount    <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            hblank    <= 1'b1;
            vblank    <= 1'b1;
            pix_valid <= 1'b0;
            line_req  <= 1'b0;
            line_addr <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: directed scenarios plus random configurations,
// checked every clock against a frame-time arithmetic reference model.
module tb_vid_timing_gen;
   logic        clk = 1'b0;
   logic        reset, en;
   logic [5:0]  pcnt;
   logic [12:0] hsize, hend, hss, hse, vsize, vend, vss, vse;
   logic [31:0] base_address, lineinc;
   logic        hsync, hblank, vsync, vblank, pix_valid, line_req, cfg_err;
   logic [12:0] hcount, vcount;
   logic [31:0] line_addr;

   vid_timing_gen dut (
      .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
      .hsize(hsize), .hend(hend), .hss(hss), .hse(hse),
      .vsize(vsize), .vend(vend), .vss(vss), .vse(vse),
      .base_address(base_address), .lineinc(lineinc),
      .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
      .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount),
      .line_req(line_req), .line_addr(line_addr), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;

   typedef struct {
      int pcnt, hsize, hend, hss, hse, vsize, vend, vss, vse;
      logic [31:0] base, inc;
   } mcfg_t;
   typedef enum {M_IDLE, M_LOAD, M_RUN, M_ERR} mmode_t;

   mmode_t      mode = M_IDLE;
   mcfg_t       mc;
   int          ft = 0;
   bit          first = 1'b0;
   logic [31:0] last_addr = '0;
   int          e_h, e_v;
   bit          e_hb, e_vb, e_hs, e_vs, e_pv, e_req, e_err;
   logic [31:0] req_log[$];

   function automatic mcfg_t inputs_now();
      mcfg_t c;
      c.pcnt = int'(pcnt);   c.hsize = int'(hsize); c.hend = int'(hend);
      c.hss  = int'(hss);    c.hse   = int'(hse);   c.vsize = int'(vsize);
      c.vend = int'(vend);   c.vss   = int'(vss);   c.vse  = int'(vse);
      c.base = base_address; c.inc   = lineinc;
      return c;
   endfunction

   function automatic bit bad(input mcfg_t c);
      return c.hsize > c.hend + 1 || c.vsize > c.vend + 1 || c.hend == 0 || c.vend == 0;
   endfunction

   function automatic int frame_len(input mcfg_t c);
      return (c.hend + 1) * (c.vend + 1) * (c.pcnt + 1);
   endfunction

   // ft is the clock count since the current frame started; position and
   // divider phase fall out of plain division.
   task automatic model_step();
      int p, px, ph, nl;
      if (reset) mode = M_IDLE;
      else case (mode)
         M_IDLE: if (en) mode = M_LOAD;
         M_LOAD: begin
            mc = inputs_now();
            if (bad(mc)) mode = M_ERR;
            else begin mode = M_RUN; ft = 0; first = 1'b1; end
         end
         M_RUN: begin
            if (!en) mode = M_IDLE;
            else if (bad(mc)) mode = M_ERR;
            else begin
               first = 1'b0;
               ft++;
               if (ft == frame_len(mc)) begin ft = 0; mc = inputs_now(); end
            end
         end
         default: if (!en) mode = M_IDLE;
      endcase

      e_err = (mode == M_ERR);
      e_req = 1'b0;
      if (mode == M_RUN) begin
         p    = mc.pcnt + 1;
         px   = ft / p;
         ph   = ft % p;
         e_h  = px % (mc.hend + 1);
         e_v  = px / (mc.hend + 1);
         e_hb = e_h >= mc.hsize;
         e_vb = e_v >= mc.vsize;
         e_hs = e_h >= mc.hss && e_h < mc.hse;
         e_vs = e_v >= mc.vss && e_v < mc.vse;
         e_pv = (ph == mc.pcnt) && !e_hb && !e_vb;
         if (first || (ph == 0 && e_h == mc.hsize)) begin
            nl = (first || e_v == mc.vend) ? 0 : e_v + 1;
            if (nl < mc.vsize) begin
               e_req     = 1'b1;
               last_addr = mc.base + 32'(nl) * mc.inc;
            end
         end
      end else begin
         e_h = 0; e_v = 0; e_hb = 1'b1; e_vb = 1'b1;
         e_hs = 1'b0; e_vs = 1'b0; e_pv = 1'b0; last_addr = '0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      chk("hcount",    32'(hcount),    32'(e_h));
      chk("vcount",    32'(vcount),    32'(e_v));
      chk("hblank",    32'(hblank),    32'(e_hb));
      chk("vblank",    32'(vblank),    32'(e_vb));
      chk("hsync",     32'(hsync),     32'(e_hs));
      chk("vsync",     32'(vsync),     32'(e_vs));
      chk("pix_valid", 32'(pix_valid), 32'(e_pv));
      chk("line_req",  32'(line_req),  32'(e_req));
      chk("line_addr", line_addr,      last_addr);
      chk("cfg_err",   32'(cfg_err),   32'(e_err));
      if (line_req === 1'b1) req_log.push_back(line_addr);
   endtask

   task automatic set_cfg(input int p, input int hs, input int he, input int h0, input int h1,
                          input int vs, input int ve, input int v0, input int v1,
                          input logic [31:0] b, input logic [31:0] inc);
      pcnt  = 6'(p);   hsize = 13'(hs); hend = 13'(he); hss = 13'(h0); hse = 13'(h1);
      vsize = 13'(vs); vend  = 13'(ve); vss  = 13'(v0); vse = 13'(v1);
      base_address = b; lineinc = inc;
   endtask

   task automatic rand_cfg();
      int he, ve;
      he = int'($urandom_range(1, 12));
      ve = int'($urandom_range(1, 6));
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(1, he + 1)), he,
              int'($urandom_range(0, he + 2)), int'($urandom_range(0, he + 2)),
              int'($urandom_range(0, ve + 1)), ve,
              int'($urandom_range(0, ve + 1)), int'($urandom_range(0, ve + 1)),
              $urandom, $urandom);
   endtask

   initial begin
      int pv;
      reset = 1'b1;
      en    = 1'b1;
      set_cfg(0, 4, 7, 5, 6, 2, 3, 3, 4, 32'h1000, 32'h40);
      cycle(); cycle();

      // basic raster: first run clock is the second cycle after release
      reset = 1'b0;
      req_log.delete();
      repeat (35) cycle();
      chk("basic_nreq", 32'(req_log.size()), 32'd3);
      while (req_log.size() < 3) req_log.push_back('1);
      chk("basic_req0", req_log[0], 32'h1000);
      chk("basic_req1", req_log[1], 32'h1040);
      chk("basic_req2", req_log[2], 32'h1000);
      repeat (31) cycle();

      // shadow reload of hsize mid-frame
      hsize = 13'd6;
      repeat (80) cycle();

      // divider
      en = 1'b0; cycle();
      set_cfg(0, 4, 7, 5, 6, 2, 3, 3, 4, 32'h1000, 32'h40);
      pcnt = 6'd2;
      en = 1'b1;
      cycle();
      pv = 0;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (pix_valid === 1'b1) pv++;
      end
      chk("div_pv_line0", 32'(pv), 32'd4);
      repeat (60) cycle();

      // disable mid-line
      for (int i = 0; i < 200 && !(mode == M_RUN && e_h == 2); i++) cycle();
      chk("dis_reached_h2", 32'(hcount), 32'd2);
      en = 1'b0;
      cycle();
      chk("dis_hblank", 32'(hblank), 32'd1);
      cycle();

      // illegal configuration at enable
      set_cfg(0, 9, 7, 5, 6, 2, 3, 3, 4, 32'h1000, 32'h40);
      en = 1'b1;
      cycle(); cycle();
      chk("err_set", 32'(cfg_err), 32'd1);
      repeat (3) cycle();
      en = 1'b0;
      cycle();
      chk("err_clear", 32'(cfg_err), 32'd0);

      // illegal reload at a frame boundary
      set_cfg(1, 4, 7, 5, 6, 2, 3, 3, 4, 32'h2000, 32'h80);
      en = 1'b1;
      repeat (10) cycle();
      hend = 13'd0;
      repeat (80) cycle();
      en = 1'b0;
      cycle();

      // reset in the middle of a run
      set_cfg(0, 3, 5, 1, 3, 2, 4, 0, 2, 32'h30, 32'h10);
      en = 1'b1;
      repeat (15) cycle();
      reset = 1'b1; cycle();
      reset = 1'b0;
      repeat (20) cycle();

      // randomized configurations, mid-run reloads and brief disables
      for (int r = 0; r < 10; r++) begin
         en = 1'b0; cycle();
         rand_cfg();
         en = 1'b1;
         for (int i = 0; i < 300; i++) begin
            cycle();
            if (i == 120) rand_cfg();
            en = ($urandom_range(0, 149) != 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Raster timing generator for the video controller. It runs from the programmed control, horizontal, vertical, base-address and line-increment register values. It produces the hsync/hblank/vsync/vblank raster, the pixel position and a per-line fetch request that the bus-master stage turns into memory reads. It sits directly downstream of the register-programming logic and upstream of the pixel output path.

## Interface
- No parameters; all field widths are fixed by the register map.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  controller enable (cr.en)
- pcnt  in  6  pixel divider; one pixel tick every pcnt+1 clocks
- hsize, hend  in  13 each  displayed / total-minus-one pixels per line
- hss, hse  in  13 each  hsync start / end pixel
- vsize, vend  in  13 each  displayed / total-minus-one lines per frame
- vss, vse  in  13 each  vsync start / end line
- base_address, lineinc  in  32 each  frame base address, byte stride per line
- hsync, hblank, vsync, vblank  out  1 each  raster timing, active-high
- pix_valid  out  1  the current pixel is displayed and ticks this clock
- hcount, vcount  out  13 each  current pixel / line
- line_req  out  1  one-clock fetch request
- line_addr  out  32  address for line_req
- cfg_err  out  1  shadow configuration is illegal

## Operation
- **Reset.** All outputs are 0 except hblank=1 and vblank=1. The state is IDLE.
- **States:**
  - IDLE -> LOAD when en=1.
  - LOAD -> RUN after one clock, or -> ERR if the configuration is illegal.
  - RUN -> IDLE when en=0, checked every clock.
  - ERR -> IDLE when en=0.
- **LOAD.**
  - Copies every configuration input into shadow registers.
  - Clears the divider, hcount and vcount.
- **Illegal configuration:**
  - hsize > hend+1, or vsize > vend+1, or hend=0, or vend=0.
  - In ERR, cfg_err=1 and the outputs hold their IDLE values.
- **Divider.**
  - dcnt counts 0..pcnt. A tick occurs when dcnt==pcnt, then dcnt wraps to 0.
  - pcnt=0 gives a tick on every clock.
- **Counters advance only on a tick:**
  - hcount wraps from shadow hend to 0.
  - On that wrap, vcount increments and wraps from vend to 0.
- **Frame-boundary reload.** At the hcount and vcount double wrap, the shadow registers reload from the inputs, so changes take effect only at a frame start. An illegal reload enters ERR on the next clock.
- **Decode**, from the shadow values and the registered outputs for the current hcount/vcount:
  - hblank = hcount >= hsize.
  - vblank = vcount >= vsize.
  - hsync = hss <= hcount < hse.
  - vsync = vss <= vcount < vse.
  - If hse <= hss, hsync never asserts; likewise for vsync.
  - pix_valid = tick & !hblank & !vblank.
- **Line fetch.**
  - line_req pulses on the first RUN clock, requesting line 0.
  - It also pulses on the clock in which hcount first equals hsize. The requested line nl = vcount+1, or 0 when vcount==vend.
  - The pulse is suppressed when nl >= vsize.
  - line_addr = base_address + nl*lineinc, computed modulo 2^32 from the shadow values.
  - line_addr is stable while line_req=1 and holds otherwise.
- **en falling in RUN.** The next clock returns every output to its reset value. A pending line_req is dropped.

## Timing
- Outputs are registered. hcount, vcount and all decodes change on the same clock edge.
- Latency: en=1 at edge N -> LOAD at N+1 -> RUN and the first line_req at N+2.
- hcount=0 and vcount=0 are visible from edge N+2.
- Line period is (hend+1)*(pcnt+1) clocks. Frame period is (vend+1) times the line period.
- line_req is high for exactly one clock. No acknowledge is needed; the consumer must accept it on that clock.
- reset has priority over en and over every state.

## Test plan
- **Reset.** Assert reset for 2 clocks with en=1 -> hblank=vblank=1, all other outputs 0, no line_req.
- **Basic raster.**
  - Stimulus: pcnt=0, hsize=4, hend=7, hss=5, hse=6, vsize=2, vend=3, vss=3, vse=4, base_address=0x1000, lineinc=0x40.
  - Line period: 8 clocks; frame period: 32 clocks.
  - hblank is high at hcount 4..7. hsync is high only at hcount 5. vblank is high at lines 2..3. vsync is high only on line 3.
  - line_req fires:
    - on the first RUN clock, line_addr=0x1000;
    - at line 0, hcount=4, line_addr=0x1040;
    - at line 3, hcount=4, line_addr=0x1000;
    - not at lines 1 or 2.
- **Divider.** pcnt=2 -> hcount advances every 3 clocks. pix_valid is high 1 clock in 3 during the active region.
- **Shadow reload.** Change hsize from 4 to 6 mid-frame -> the hblank timing is unchanged until the next vcount=0, hcount=0, then hblank starts at hcount 6.
- **Disable mid-line.** Drop en at hcount=2 -> on the next clock, hcount=vcount=0, hblank=vblank=1, syncs=0, and no line_req.
- **Illegal configuration.** Enable with hsize=9, hend=7 -> ERR with cfg_err=1 from edge N+2. Dropping en clears cfg_err on the next clock.
